// File: rtl/sign_extend_pipe.sv
// rtl/sign_extend_pipe.sv - pipelined parametrised sign/zero extender with one-deep skid buffer
module sign_extend_pipe #(
    parameter  int IN_W  = 12,
    parameter  int OUT_W = 32,
    localparam int LEN_W = $clog2(IN_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_zext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [OUT_W-1:0] out_data_q;
    logic             out_err_q;
    logic [OUT_W-1:0] skid_data;
    logic             skid_err;

    logic [OUT_W-1:0] data_wide;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;
    logic             fill;
    logic             acc;
    logic             pop;

    // Extension is resolved before capture so both holding registers store final results.
    always_comb begin
        data_wide = OUT_W'(in_data);
        ext_err   = (in_len == '0) || (int'(in_len) > IN_W);
        fill      = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (int'(in_len) == i + 1) begin
                fill = in_data[i] & ~in_zext;
            end
        end
        ext_data = '0;
        for (int i = 0; i < OUT_W; i++) begin
            ext_data[i] = (i < int'(in_len)) ? data_wide[i] : fill;
        end
        if (ext_err) begin
            ext_data = '0;
        end
    end

    assign acc = in_valid && in_ready_q;
    assign pop = out_valid_q && out_ready;

    // in_ready is a register so out_ready never reaches the upstream handshake combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            skid_data   <= '0;
            skid_err    <= 1'b0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (acc) begin
                        out_data_q  <= ext_data;
                        out_err_q   <= ext_err;
                        out_valid_q <= 1'b1;
                        state       <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (acc && pop) begin
                        out_data_q <= ext_data;
                        out_err_q  <= ext_err;
                    end else if (acc) begin
                        skid_data  <= ext_data;
                        skid_err   <= ext_err;
                        in_ready_q <= 1'b0;
                        state      <= S_FULL;
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                        state       <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        out_data_q <= skid_data;
                        out_err_q  <= skid_err;
                        in_ready_q <= 1'b1;
                        state      <= S_ONE;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: doc/sign_extend_pipe.md
# sign_extend_pipe

Parametrised, pipelined successor to the fixed 12→32 extender in the immediate path. Takes an IN_W-bit field with a per-transaction effective length and mode (sign or zero extension) and produces an OUT_W-bit result. It sits between immediate concatenation and the ALU operand mux. A valid/ready handshake with a one-deep skid buffer lets it stall cleanly under backpressure without losing or reordering transactions.

## Interface
- IN_W, default 12: physical input field width; legal range 1..OUT_W.
- OUT_W, default 32: output width; must be ≥ IN_W.
- LEN_W, derived as $clog2(IN_W+1): width of in_len; not overridable.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream transaction present.
- in_ready  output  1  block can accept; a transfer happens when in_valid && in_ready at a rising edge.
- in_data  input  IN_W  raw field, LSB-aligned.
- in_len  input  LEN_W  effective field length L; valid values are 1..IN_W.
- in_zext  input  1  0 = sign-extend from bit L-1; 1 = zero-extend.
- out_valid  output  1  out_data/out_err hold a transaction.
- out_ready  input  1  downstream accepts; a transfer happens when out_valid && out_ready at a rising edge.
- out_data  output  OUT_W  extended result.
- out_err  output  1  set for an illegal in_len; travels with its transaction.

## Operation
- Extension rule for a legal L:
  - out_data[L-1:0] = in_data[L-1:0].
  - out_data[OUT_W-1:L] = in_zext ? 0 : in_data[L-1].
  - in_data bits at L and above are ignored.
  - out_err = 0.
- Illegal L (L == 0 or L > IN_W): out_data = 0 and out_err = 1. The transaction is still accepted and delivered, never dropped.
- The extension is computed combinationally on the input side. The result plus err is captured in one of two registers:
  - OUT reg: drives out_data/out_err; flag out_v drives out_valid.
  - SKID reg: flag skid_v.
  - in_ready = !skid_v, driven from a register with no combinational path from out_ready.
- Per rising edge, with acc = in_valid && in_ready and pop = out_v && out_ready:
  - EMPTY (out_v=0, skid_v=0): on acc, load OUT.
  - ONE (out_v=1, skid_v=0):
    - acc && pop: load OUT with the new item.
    - acc && !pop: load SKID; in_ready falls.
    - !acc && pop: go to EMPTY.
  - FULL (out_v=1, skid_v=1): in_ready=0. On pop, move SKID into OUT and clear skid_v.
- Transactions leave in acceptance order; no reordering is permitted.
- out_data/out_err change only on a load. The contents of a non-popped OUT stay stable while out_valid=1 && out_ready=0.

## Timing
- Reset (rst_n low, asynchronous): out_v=0, skid_v=0, out_data=0, out_err=0, SKID contents=0. in_ready reads 1 once out of reset. in_valid is ignored while rst_n=0.
- Reset mid-operation: all held transactions are discarded immediately, with no partial output.
- Latency: an item accepted at edge k is visible on out_data with out_valid=1 from just after edge k (one cycle).
- Throughput: one transaction per cycle while out_ready stays high.
- Backpressure:
  - At most 2 transactions are held.
  - in_ready drops the cycle after the second item is accepted.
  - in_ready rises the cycle after the SKID→OUT move.
- Simultaneous acc and pop in ONE: both happen on the same edge; occupancy stays at 1.
- L == IN_W == OUT_W: pure pass-through; in_zext has no effect.

## Test plan
- Sign, L=12, in_data=12'h800, in_zext=0, out_ready=1 → next cycle out_data=32'hFFFF_F800, out_err=0.
- Zero, L=12, in_data=12'h800, in_zext=1 → out_data=32'h0000_0800. Then L=5, in_data=12'hF10, in_zext=0 → out_data=32'hFFFF_FFF0 (bits above 4 ignored).
- Illegal lengths: L=0 → out_data=0, out_err=1. L=13 with IN_W=12 → out_data=0, out_err=1. The next legal item has out_err=0.
- Backpressure: stream items 1,2,3 with out_ready=0.
  - Items 1 and 2 accepted; in_ready=0 from the third cycle; out_data holds item 1 steady.
  - Raise out_ready → items 1, 2, 3 emerge in order; in_ready returns to 1 one cycle after the SKID→OUT move.
- Full throughput: 100 back-to-back random items with out_ready=1 → 100 outputs, each exactly one cycle after acceptance, all matching a reference model.
- Async reset in FULL: deassert rst_n mid-cycle → out_valid=0 and out_data=0 immediately. After release in_ready=1, and no stale item appears.
